// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        HOLD
    } ARB_STATE;

    // Width of a requester index; never narrower than one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after
// lastIdx+1 (mod NumReq, with wrap) that has req set.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NumReq = 4,
    localparam int IdxW = idxWidth(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   lastIdx,
    output logic [IdxW-1:0]   idx,
    output logic              any
);

    int              cand;
    logic [IdxW-1:0] candIdx;

    // Scan every position once, starting just after the previous owner.
    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        idx     = '0;
        any     = 1'b0;
        cand    = 0;
        candIdx = '0;
        for (int k = 1; k <= NumReq; k++) begin
            cand    = (int'(lastIdx) + k) % NumReq;
            candIdx = IdxW'(cand);
            if (!any && req[candIdx]) begin
                any = 1'b1;
                idx = candIdx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UartTxEn transmitter between NumReq byte-stream requesters.
// Round-robin arbitration with packet lock: the owner keeps the transmitter
// until it sends a byte flagged last. Each byte is issued as data plus a
// one-cycle valid pulse, then the arbiter waits for the done pulse.
// Optional build macro UART_ARB_HOLD_TIMEOUT_EN: drop the lock after
// HoldTimeout idle cycles in HOLD and pulse timedOut.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NumReq      = 4,
    parameter int HoldTimeout = 1024
) (
    input  logic                     clk,
    input  logic                     nReset,
    input  logic [NumReq-1:0]        reqValid,
    input  logic [NumReq*BYTE_W-1:0] reqData,
    input  logic [NumReq-1:0]        reqLast,
    output logic [NumReq-1:0]        reqReady,
    output logic [BYTE_W-1:0]        txData,
    output logic                     txValid,
    input  logic                     txDone,
    output logic [NumReq-1:0]        grant,
    output logic                     busy,
    output logic                     timedOut
);

    localparam int IdxW = idxWidth(NumReq);

    if (NumReq < 2 || NumReq > 8) begin : gBadNumReq
        $error("uart_tx_arbiter: NumReq must be in 2..8");
    end
    if (HoldTimeout < 1) begin : gBadHoldTimeout
        $error("uart_tx_arbiter: HoldTimeout must be at least 1");
    end

    ARB_STATE          state;
    ARB_STATE          nextState;
    logic [IdxW-1:0]   pickIdx;
    logic              pickAny;
    logic [IdxW-1:0]   grantIdx;
    logic [IdxW-1:0]   lastIdx;
    logic              lastFlag;
    logic [IdxW-1:0]   selIdx;
    logic [BYTE_W-1:0] selData;
    logic              selLast;
    logic              accept;
    logic              dropLock;
    logic              timeoutHit;

    uart_rr_pick #(
        .NumReq (NumReq)
    ) uPick (
        .req     (reqValid),
        .lastIdx (lastIdx),
        .idx     (pickIdx),
        .any     (pickAny)
    );

    // Ready goes to the round-robin winner in IDLE, or only to the owner in HOLD.
    always_comb begin
        reqReady = '0;
        selIdx   = grantIdx;
        case (state)
            IDLE: begin
                selIdx = pickIdx;
                if (pickAny) begin
                    reqReady = NumReq'(1) << pickIdx;
                end
            end
            HOLD:    reqReady = grant & reqValid;
            default: ;
        endcase
    end

    assign accept = |(reqReady & reqValid);

    // Mux the byte and last flag of the requester being served.
    always_comb begin
        selData = '0;
        selLast = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            if (selIdx == IdxW'(i)) begin
                selData = reqData[i*BYTE_W +: BYTE_W];
                selLast = reqLast[i];
            end
        end
    end

`ifdef UART_ARB_HOLD_TIMEOUT_EN
    localparam int CntW = $clog2(HoldTimeout + 1);
    logic [CntW-1:0] holdCount;

    // Count consecutive HOLD cycles with no byte accepted; clear otherwise.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            holdCount <= '0;
        end else if (state == HOLD && !accept && !timeoutHit) begin
            holdCount <= holdCount + CntW'(1);
        end else begin
            holdCount <= '0;
        end
    end
`endif

    // Next-state decode; also flags when the lock is released.
    always_comb begin
        nextState  = state;
        dropLock   = 1'b0;
        timeoutHit = 1'b0;
        case (state)
            IDLE: begin
                if (accept) nextState = ISSUE;
            end
            ISSUE: nextState = WAIT_DONE;
            WAIT_DONE: begin
                if (txDone) begin
                    if (lastFlag) begin
                        dropLock  = 1'b1;
                        nextState = IDLE;
                    end else begin
                        nextState = HOLD;
                    end
                end
            end
            HOLD: begin
                if (accept) begin
                    nextState = ISSUE;
                end
`ifdef UART_ARB_HOLD_TIMEOUT_EN
                else if (holdCount == CntW'(HoldTimeout)) begin
                    timeoutHit = 1'b1;
                    dropLock   = 1'b1;
                    nextState  = IDLE;
                end
`endif
            end
            default: nextState = IDLE;
        endcase
    end

    // State register plus the byte, last flag and ownership captured on accept.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            txData   <= '0;
            lastFlag <= 1'b0;
            grant    <= '0;
            grantIdx <= '0;
            lastIdx  <= IdxW'(NumReq - 1);
        end else begin
            state <= nextState;
            if (accept) begin
                txData   <= selData;
                lastFlag <= selLast;
                if (state == IDLE) begin
                    grant    <= reqReady;
                    grantIdx <= pickIdx;
                end
            end
            if (dropLock) begin
                grant   <= '0;
                lastIdx <= grantIdx;
            end
        end
    end

    assign txValid  = (state == ISSUE);
    assign busy     = (state != IDLE);
    assign timedOut = timeoutHit;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. A transaction-level model checks
// every output each cycle; directed scenarios add literal expectations.
// Define UART_ARB_HOLD_TIMEOUT_EN for both bench and RTL to run the timeout case.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int NumReq      = 4;
    localparam int HoldTimeout = 8;
    localparam int DoneDelay   = 10;
    localparam int QDepth      = 16;
    localparam int LogDepth    = 64;

    logic                     clk      = 1'b0;
    logic                     nReset   = 1'b0;
    logic [NumReq-1:0]        reqValid = '0;
    logic [NumReq*BYTE_W-1:0] reqData  = '0;
    logic [NumReq-1:0]        reqLast  = '0;
    logic                     txDone   = 1'b0;
    logic [NumReq-1:0]        reqReady;
    logic [BYTE_W-1:0]        txData;
    logic                     txValid;
    logic [NumReq-1:0]        grant;
    logic                     busy;
    logic                     timedOut;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NumReq      (NumReq),
        .HoldTimeout (HoldTimeout)
    ) dut (
        .clk      (clk),
        .nReset   (nReset),
        .reqValid (reqValid),
        .reqData  (reqData),
        .reqLast  (reqLast),
        .reqReady (reqReady),
        .txData   (txData),
        .txValid  (txValid),
        .txDone   (txDone),
        .grant    (grant),
        .busy     (busy),
        .timedOut (timedOut)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Requester byte queues, transmitter responder and observation log.
    logic [8:0] mem [NumReq][QDepth];
    int         head [NumReq];
    int         tail [NumReq];
    int         respCnt  = 0;
    logic       respDone = 1'b0;
    logic       injPulse = 1'b0;
    int         cyc      = 0;
    int         logOwner [LogDepth];
    int         logData  [LogDepth];
    int         logN     = 0;
    int         toCount  = 0;
    int         toCyc    = 0;
    int         doneCyc  = 0;
    int         blocked  = 0;

    function automatic int ownerOf(input logic [NumReq-1:0] g);
        for (int i = 0; i < NumReq; i++) if (g[i]) return i;
        return -1;
    endfunction

    function automatic bit allEmpty();
        for (int i = 0; i < NumReq; i++) if (head[i] != tail[i]) return 1'b0;
        return 1'b1;
    endfunction

    // ---------------- behavioural model and per-cycle compare ----------------
    int                mOwner     = -1;
    int                mLastOwner = NumReq - 1;
    int                mIdle      = 0;
    int                mW         = 0;
    int                mc         = 0;
    logic [7:0]        mData      = '0;
    bit                mPulse     = 1'b0;
    bit                mInFlight  = 1'b0;
    bit                mLast      = 1'b0;
    bit                mHolding   = 1'b0;
    bit                mAcc       = 1'b0;
    bit                mFound     = 1'b0;
    bit                expTo      = 1'b0;
    logic [NumReq-1:0] expReady   = '0;
    logic [NumReq-1:0] expGrant   = '0;

    always @(negedge clk) begin
        if (!nReset) begin
            mOwner = -1; mLastOwner = NumReq - 1; mIdle = 0; mData = '0;
            mPulse = 1'b0; mInFlight = 1'b0; mLast = 1'b0;
            check("rst_grant", grant, 0);
            check("rst_busy", busy, 0);
            check("rst_txValid", txValid, 0);
            check("rst_txData", txData, 0);
            check("rst_timedOut", timedOut, 0);
        end else begin
            expReady = '0;
            expTo    = 1'b0;
            mHolding = (mOwner >= 0) && !mPulse && !mInFlight;
            if (mOwner < 0) begin
                mFound = 1'b0;
                for (int k = 1; k <= NumReq; k++) begin
                    mc = (mLastOwner + k) % NumReq;
                    if (!mFound && reqValid[mc]) begin
                        mFound = 1'b1;
                        mW     = mc;
                        expReady[mc] = 1'b1;
                    end
                end
            end else if (mHolding) begin
                mW = mOwner;
                expReady[mOwner] = reqValid[mOwner];
            end
            mAcc = |(expReady & reqValid);
`ifdef UART_ARB_HOLD_TIMEOUT_EN
            if (mHolding && !mAcc && mIdle == HoldTimeout) expTo = 1'b1;
`endif
            expGrant = (mOwner < 0) ? '0 : (NumReq'(1) << mOwner);
            check("reqReady", reqReady, expReady);
            check("grant", grant, expGrant);
            check("busy", busy, (mOwner >= 0));
            check("txValid", txValid, mPulse);
            check("txData", txData, mData);
            check("timedOut", timedOut, expTo);

            if (mOwner < 0) begin
                if (mAcc) begin
                    mOwner = mW; mData = reqData[mW*8 +: 8]; mLast = reqLast[mW]; mPulse = 1'b1;
                end
            end else if (mPulse) begin
                mPulse = 1'b0; mInFlight = 1'b1;
            end else if (mInFlight) begin
                if (txDone) begin
                    mInFlight = 1'b0;
                    if (mLast) begin mLastOwner = mOwner; mOwner = -1; end
                end
            end else begin
                if (mAcc) begin
                    mData = reqData[mW*8 +: 8]; mLast = reqLast[mW]; mPulse = 1'b1; mIdle = 0;
                end else if (expTo) begin
                    mLastOwner = mOwner; mOwner = -1; mIdle = 0;
                end else begin
                    mIdle++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load(input int r, input logic [7:0] d, input logic l);
        mem[r][tail[r]] = {l, d};
        tail[r]++;
    endtask

    task automatic clearBench();
        for (int i = 0; i < NumReq; i++) begin head[i] = 0; tail[i] = 0; end
        reqValid = '0; reqData = '0; reqLast = '0;
        respCnt = 0; respDone = 1'b0; injPulse = 1'b0; txDone = 1'b0;
        logN = 0; toCount = 0; blocked = 0;
    endtask

    // One clock: pop accepted bytes, run the responder, drive, then observe.
    task automatic tick();
        logic [NumReq-1:0] acc;
        @(negedge clk);
        acc = reqValid & reqReady;
        @(posedge clk);
        #1;
        cyc++;
        respDone = 1'b0;
        if (!nReset) begin
            respCnt = 0;
        end else if (respCnt > 0) begin
            respCnt--;
            if (respCnt == 0) respDone = 1'b1;
        end
        for (int i = 0; i < NumReq; i++) if (acc[i]) head[i]++;
        txDone   = respDone | injPulse;
        injPulse = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            if (head[i] < tail[i]) begin
                reqValid[i]          = 1'b1;
                reqData[i*8 +: 8]    = mem[i][head[i]][7:0];
                reqLast[i]           = mem[i][head[i]][8];
            end else begin
                reqValid[i]          = 1'b0;
                reqData[i*8 +: 8]    = '0;
                reqLast[i]           = 1'b0;
            end
        end
        #1;
        if (txValid && logN < LogDepth) begin
            logOwner[logN] = ownerOf(grant);
            logData[logN]  = int'(txData);
            logN++;
        end
        if (txValid) respCnt = DoneDelay;
        if (respDone) doneCyc = cyc;
        if (timedOut) begin toCount++; toCyc = cyc; end
        if (reqReady[2] && grant[1]) blocked++;
    endtask

    task automatic doReset();
        nReset = 1'b0;
        clearBench();
        tick();
        tick();
        nReset = 1'b1;
        tick();
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n = 0;
        while ((!allEmpty() || busy || respCnt != 0 || respDone) && n < budget) begin
            tick();
            n++;
        end
        check(name, (n < budget), 1);
    endtask

    task automatic waitRespDone(input string name, input int budget);
        int n = 0;
        while (!respDone && n < budget) begin
            tick();
            n++;
        end
        check(name, (n < budget), 1);
    endtask

    int expOrder [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int expOwn3  [4] = '{1, 1, 1, 2};
    int expDat3  [4] = '{'h10, 'h11, 'h12, 'h20};

    initial begin
        int n;
        int d;
        doReset();
        check("reset_grant", grant, 0);
        check("reset_busy", busy, 0);
        check("reset_txValid", txValid, 0);
        check("reset_txData", txData, 0);

        // Single-byte packet from requester 0.
        load(0, 8'h41, 1'b1);
        tick();
        check("t1_ready_same_cycle", reqReady, 4'b0001);
        tick();
        check("t1_txValid", txValid, 1);
        check("t1_txData", txData, 'h41);
        check("t1_grant", grant, 4'b0001);
        waitIdle("t1_idle_timeout", 60);
        check("t1_grant_released", grant, 0);
        check("t1_busy_clear", busy, 0);
        check("t1_bytes", logN, 1);

        // All four valid, every byte last: strict round robin.
        doReset();
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < NumReq; i++) load(i, 8'(8'hA0 + 16*i + j), 1'b1);
        waitIdle("t2_idle_timeout", 400);
        check("t2_bytes", logN, 8);
        for (int k = 0; k < 8; k++) check($sformatf("t2_owner%0d", k), logOwner[k], expOrder[k]);

        // Packet lock: requester 1 sends three bytes while requester 2 waits.
        doReset();
        load(1, 8'h10, 1'b0);
        load(1, 8'h11, 1'b0);
        load(1, 8'h12, 1'b1);
        load(2, 8'h20, 1'b1);
        waitIdle("t3_idle_timeout", 200);
        check("t3_bytes", logN, 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t3_owner%0d", k), logOwner[k], expOwn3[k]);
            check($sformatf("t3_data%0d", k), logData[k], expDat3[k]);
        end
        check("t3_req2_blocked", blocked, 0);

        // Stray txDone in IDLE and in HOLD is ignored.
        doReset();
        injPulse = 1'b1;
        tick();
        tick();
        check("t4_idle_done_busy", busy, 0);
        check("t4_idle_done_bytes", logN, 0);
        load(0, 8'h55, 1'b0);
        waitRespDone("t4_done_timeout", 60);
        tick();
        injPulse = 1'b1;
        tick();
        tick();
        tick();
        check("t4_hold_busy", busy, 1);
        check("t4_hold_grant", grant, 4'b0001);
        check("t4_hold_bytes", logN, 1);
        load(0, 8'h56, 1'b1);
        waitIdle("t4_idle_timeout", 60);
        check("t4_bytes", logN, 2);
        check("t4_data1", logData[1], 'h56);
        check("t4_owner1", logOwner[1], 0);

        // Asynchronous reset while waiting for done.
        doReset();
        load(0, 8'h60, 1'b1);
        waitIdle("t5_first_timeout", 60);
        load(1, 8'h61, 1'b1);
        n = 0;
        while (logN < 2 && n < 20) begin tick(); n++; end
        check("t5_issue_timeout", (n < 20), 1);
        tick();
        #1 nReset = 1'b0;
        #1;
        check("t5_async_grant", grant, 0);
        check("t5_async_busy", busy, 0);
        check("t5_async_txValid", txValid, 0);
        check("t5_async_txData", txData, 0);
        check("t5_async_ready", reqReady, 0);
        clearBench();
        tick();
        tick();
        nReset = 1'b1;
        tick();
        load(0, 8'h70, 1'b1);
        load(1, 8'h71, 1'b1);
        waitIdle("t5_idle_timeout", 100);
        check("t5_bytes", logN, 2);
        check("t5_first_owner", logOwner[0], 0);
        check("t5_second_owner", logOwner[1], 1);

`ifdef UART_ARB_HOLD_TIMEOUT_EN
        // Hold timeout: owner 0 goes quiet after a non-last byte.
        doReset();
        load(0, 8'h90, 1'b0);
        load(1, 8'h91, 1'b1);
        waitRespDone("t6_done_timeout", 60);
        d = doneCyc;
        n = 0;
        while (toCount == 0 && n < 40) begin tick(); n++; end
        check("t6_timeout_seen", (n < 40), 1);
        check("t6_timeout_cycle", toCyc - d, 9);
        waitIdle("t6_idle_timeout", 100);
        check("t6_timeout_pulses", toCount, 1);
        check("t6_bytes", logN, 2);
        check("t6_next_owner", logOwner[1], 1);
`else
        d = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
